// File: rtl/display_pkg.sv
// Shared constants and types for the digit display path.
// Segment patterns are active-high {g,f,e,d,c,b,a}; output polarity is applied at the pins.
package display_pkg;

  localparam int DEFAULT_NUM_DIGITS = 10;

  localparam logic [6:0] SEG_ZERO  = 7'h3F;
  localparam logic [6:0] SEG_ONE   = 7'h06;
  localparam logic [6:0] SEG_TWO   = 7'h5B;
  localparam logic [6:0] SEG_THREE = 7'h4F;
  localparam logic [6:0] SEG_FOUR  = 7'h66;
  localparam logic [6:0] SEG_FIVE  = 7'h6D;
  localparam logic [6:0] SEG_SIX   = 7'h7D;
  localparam logic [6:0] SEG_SEVEN = 7'h07;
  localparam logic [6:0] SEG_EIGHT = 7'h7F;
  localparam logic [6:0] SEG_NINE  = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  typedef enum logic [1:0] {
    ADDR    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    SHOW    = 2'd3
  } state_e;

endpackage

// File: rtl/display_scan_seg7_decode.sv
// Combinational 4-bit value to active-high 7-segment pattern.
// Values above 9 (including undefined register reads) show a dash.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (value)
      4'd0:    seg = SEG_ZERO;
      4'd1:    seg = SEG_ONE;
      4'd2:    seg = SEG_TWO;
      4'd3:    seg = SEG_THREE;
      4'd4:    seg = SEG_FOUR;
      4'd5:    seg = SEG_FIVE;
      4'd6:    seg = SEG_SIX;
      4'd7:    seg = SEG_SEVEN;
      4'd8:    seg = SEG_EIGHT;
      4'd9:    seg = SEG_NINE;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Scans the display register read port one digit per slot and drives the
// multiplexed segment/anode pins, with a two-cycle dark gap between digits.
module display_scan
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  blank,
  input  logic [3:0]            rd_data,
  output logic [3:0]            rd_index,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [3:0]    IDX_LAST = 4'(NUM_DIGITS - 1);

  // Valid/ready does not apply here: rd_index is a free-running address and
  // rd_data is trusted one cycle after rd_index changes, with no handshake.

  logic [CW-1:0]         cnt;
  state_e                state;
  logic                  first_slot;
  logic [3:0]            digit_q;
  logic [3:0]            dec_in;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;

  // Fresh data at CAPTURE; afterwards the latch, so unblanking mid-slot relights the same digit.
  assign dec_in = (state == CAPTURE) ? rd_data : digit_q;

  seg7_decode u_decode (
    .value (dec_in),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      state      <= ADDR;
      first_slot <= 1'b1;
      rd_index   <= '0;
      digit_q    <= '0;
      seg_q      <= '0;
      an_q       <= '0;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

      case (state)
        ADDR: begin
          state      <= WAIT;
          first_slot <= 1'b0;
          if (!first_slot)
            rd_index <= (rd_index == IDX_LAST) ? 4'd0 : rd_index + 4'd1;
        end
        WAIT:    state <= CAPTURE;
        CAPTURE: begin
          state   <= SHOW;
          digit_q <= rd_data;
        end
        SHOW:    if (cnt == CNT_LAST) state <= ADDR;
        default: state <= ADDR;
      endcase

      // Segments go dark together with the anodes so the idle level is uniform.
      if (blank || state == ADDR || state == WAIT) begin
        seg_q <= '0;
        an_q  <= '0;
      end else begin
        seg_q <= dec_seg;
        an_q  <= NUM_DIGITS'(1) << rd_index;
      end
    end
  end

  assign seg = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign an  = SEG_ACTIVE_LOW ? ~an_q  : an_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: one active-low and one active-high instance driven
// by the same stimulus, checked every cycle against a slot-level model.
module tb_display_scan;

  localparam int ND = 10;
  localparam int R  = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic blank = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    rd_data_l, rd_data_h, rd_index_l, rd_index_h;
  logic [6:0]    seg_l, seg_h;
  logic [ND-1:0] an_l, an_h;

  display_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .blank(blank), .rd_data(rd_data_l),
    .rd_index(rd_index_l), .seg(seg_l), .an(an_l)
  );

  display_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .blank(blank), .rd_data(rd_data_h),
    .rd_index(rd_index_h), .seg(seg_h), .an(an_h)
  );

  // display register model: one-cycle delayed lookup, undefined reads return F
  logic [3:0] lut [ND];

  function automatic logic [3:0] lut_rd(input logic [3:0] i);
    if (i < 4'(ND)) return lut[i];
    return 4'hF;
  endfunction

  always @(posedge clk) begin
    rd_data_l <= lut_rd(rd_index_l);
    rd_data_h <= lut_rd(rd_index_h);
  end

  function automatic logic [6:0] pattern(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  // scoreboard bookkeeping
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // model time base: edges since reset release, blank as seen at each edge
  int   n_edges;
  logic blank_s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  always @(posedge clk) blank_s <= blank;

  // compare process
  int            e_m;
  logic [3:0]    exp_idx;
  logic [3:0]    exp_val = 4'd0;
  logic [ND-1:0] exp_an, exp_an_inv;
  logic [6:0]    exp_seg, exp_seg_inv;

  always @(negedge clk) begin
    exp_an  = '0;
    exp_seg = '0;
    exp_idx = 4'd0;
    if (rst_n && n_edges > 0) begin
      e_m     = n_edges - 1;
      exp_idx = 4'((e_m / R) % ND);
      if (e_m % R == 1) exp_val = lut[exp_idx];
      if (!blank_s && (e_m % R) >= 2) begin
        exp_an  = ND'(1) << exp_idx;
        exp_seg = pattern(exp_val);
      end
    end
    exp_an_inv  = ~exp_an;
    exp_seg_inv = ~exp_seg;
    chk("rd_index_l", 32'(rd_index_l), 32'(exp_idx));
    chk("seg_l",      32'(seg_l),      32'(exp_seg_inv));
    chk("an_l",       32'(an_l),       32'(exp_an_inv));
    chk("rd_index_h", 32'(rd_index_h), 32'(exp_idx));
    chk("seg_h",      32'(seg_h),      32'(exp_seg));
    chk("an_h",       32'(an_h),       32'(exp_an));
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pin(input string name, input logic [3:0] idx,
                     input logic [ND-1:0] an_exp, input logic [6:0] seg_exp);
    logic [ND-1:0] an_inv;
    logic [6:0]    seg_inv;
    an_inv  = ~an_exp;
    seg_inv = ~seg_exp;
    chk({name, "_idx"},   32'(rd_index_l), 32'(idx));
    chk({name, "_an_l"},  32'(an_l),       32'(an_inv));
    chk({name, "_seg_l"}, 32'(seg_l),      32'(seg_inv));
    chk({name, "_an_h"},  32'(an_h),       32'(an_exp));
    chk({name, "_seg_h"}, 32'(seg_h),      32'(seg_exp));
  endtask

  initial begin
    logic [3:0] init_vals [ND];
    init_vals = '{4'd3, 4'd7, 4'd0, 4'd9, 4'd1, 4'd5, 4'd2, 4'd8, 4'd6, 4'd4};
    for (int i = 0; i < ND; i++) lut[i] = init_vals[i];

    tick(3);
    pin("reset", 4'd0, 10'h000, 7'h00);
    rst_n = 1'b1;

    // first two digits, then blank over edges 20..30 and relight at edge 31
    tick(3);
    pin("digit0_edge2", 4'd0, 10'h001, 7'h4F);
    tick(8);
    pin("digit1_edge10", 4'd1, 10'h002, 7'h07);
    tick(9);
    blank = 1'b1;
    tick(11);
    pin("blanked_edge30", 4'd3, 10'h000, 7'h00);
    blank = 1'b0;
    tick(1);
    pin("relight_edge31", 4'd3, 10'h008, 7'h6F);
    tick(49);
    pin("wrap_edge80", 4'd0, 10'h000, 7'h00);

    // reset mid-SHOW
    tick(3);
    rst_n = 1'b0;
    #1;
    pin("async_reset", 4'd0, 10'h000, 7'h00);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    pin("restart_edge2", 4'd0, 10'h001, 7'h4F);

    // out-of-range value shows a dash
    lut[4] = 4'hC;
    tick(32);
    pin("dash_edge34", 4'd4, 10'h010, 7'h40);

    // randomized phase
    for (int t = 0; t < 1500; t++) begin
      if (n_edges > 0 && ((n_edges - 1) % R) >= 3 && $urandom_range(0, 3) == 0)
        lut[$urandom_range(0, ND - 1)] = 4'($urandom_range(0, 15));
      blank = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      tick(1);
    end
    blank = 1'b0;
    tick(2 * R);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
